// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared owner encoding and default widths for the data memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_HOST} owner_e;
  localparam int AW_D = 8;
  localparam int DW_D = 8;
  localparam int MAX_LOCK_D = 16;
  localparam int CTW_D = 16;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: core, host and DataMem pins of the data memory arbiter
interface dmem_port_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_D,
  parameter int DW = DW_D,
  parameter int CTW = CTW_D
);
  logic core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [CTW-1:0] conflict_ct;
  modport slave (
    input core_req, core_we, core_addr, core_wdata,
    input host_req, host_we, host_lock, host_addr, host_wdata, mem_rdata,
    output core_gnt, core_rvalid, core_rdata, host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_we, mem_wdata, conflict_ct
  );
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output host_req, host_we, host_lock, host_addr, host_wdata, mem_rdata,
    input core_gnt, core_rvalid, core_rdata, host_gnt, host_rvalid, host_rdata,
    input mem_addr, mem_we, mem_wdata, conflict_ct
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational owner selection (round-robin with bounded host lock)
module dmem_arb_pick
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = MAX_LOCK_D,
  localparam int LW = $clog2(MAX_LOCK + 1)
) (
  input  logic          core_req,
  input  logic          host_req,
  input  logic          host_lock,
  input  logic          last_host,
  input  logic [LW-1:0] lock_ct,
  output logic          locked,
  output owner_e        owner
);
  always_comb begin
    locked = host_req & host_lock & last_host;
    owner = !host_req ? (core_req ? OWN_CORE : OWN_NONE) :
            !core_req ? OWN_HOST :
            (locked && lock_ct == LW'(MAX_LOCK)) ? OWN_CORE :
            (locked || !last_host) ? OWN_HOST : OWN_CORE;
  end
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares single-port DataMem between core and host, registered read return
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = AW_D,
  parameter int DW = DW_D,
  parameter int MAX_LOCK = MAX_LOCK_D,
  parameter int CTW = CTW_D
) (
  input logic Clk,
  input logic Reset,
  dmem_port_arbiter_if.slave bus
);
  localparam int LW = $clog2(MAX_LOCK + 1);
  owner_e owner;
  logic locked, last_host;
  logic [LW-1:0] lock_ct;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  dmem_arb_pick #(.MAX_LOCK(MAX_LOCK)) u_pick (
    .core_req(bus.core_req),
    .host_req(bus.host_req),
    .host_lock(bus.host_lock),
    .last_host(last_host),
    .lock_ct(lock_ct),
    .locked(locked),
    .owner(owner)
  );
  always_comb begin
    bus.core_gnt = owner == OWN_CORE;
    bus.host_gnt = owner == OWN_HOST;
    bus.mem_we = bus.core_gnt ? bus.core_we : bus.host_gnt & bus.host_we;
    bus.mem_addr = bus.core_gnt ? bus.core_addr : bus.host_gnt ? bus.host_addr : addr_q;
    bus.mem_wdata = bus.core_gnt ? bus.core_wdata : bus.host_gnt ? bus.host_wdata : wdata_q;
  end
  // Address/data registers let the memory pins hold their last granted values when idle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_host <= 1'b1;
      lock_ct <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      bus.core_rvalid <= 1'b0;
      bus.host_rvalid <= 1'b0;
      bus.core_rdata <= '0;
      bus.host_rdata <= '0;
      bus.conflict_ct <= '0;
    end else begin
      if (owner != OWN_NONE) begin
        last_host <= owner == OWN_HOST;
        addr_q <= bus.mem_addr;
        wdata_q <= bus.mem_wdata;
      end
      lock_ct <= (!bus.host_lock || bus.core_gnt) ? '0 :
                 (bus.host_gnt && locked && lock_ct != LW'(MAX_LOCK)) ? lock_ct + 1'b1 : lock_ct;
      bus.core_rvalid <= bus.core_gnt & !bus.core_we;
      bus.host_rvalid <= bus.host_gnt & !bus.host_we;
      if (bus.core_gnt && !bus.core_we) bus.core_rdata <= bus.mem_rdata;
      if (bus.host_gnt && !bus.host_we) bus.host_rdata <= bus.mem_rdata;
      if (bus.core_req && bus.host_req && !(&bus.conflict_ct)) bus.conflict_ct <= bus.conflict_ct + 1'b1;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: vector table plus lock/reset/saturation sequences with read scoreboard
module tb_dmem_port_arbiter;
  typedef struct {
    logic cr, cw; logic [7:0] ca, cd;
    logic hr, hw, hl; logic [7:0] ha, hd;
    logic gc, gh;
  } vec_t;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int tests = 0;
  int fails = 0;
  int conf = 0;
  logic [7:0] last_addr = '0;
  logic [7:0] last_wd = '0;
  logic [7:0] shadow [256];
  logic [7:0] mem [256];
  logic [7:0] qc [$];
  logic [7:0] qh [$];
  vec_t tbl [$];
  dmem_port_arbiter_if #(.AW(8), .DW(8), .CTW(4)) bus ();
  dmem_port_arbiter #(.AW(8), .DW(8), .MAX_LOCK(16), .CTW(4)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );
  always #5 Clk = ~Clk;
  always @(posedge Clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];
  function automatic vec_t mk(logic cr, logic cw, logic [7:0] ca, logic [7:0] cd,
                              logic hr, logic hw, logic hl, logic [7:0] ha, logic [7:0] hd,
                              logic gc, logic gh);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.hr = hr; v.hw = hw; v.hl = hl; v.ha = ha; v.hd = hd;
    v.gc = gc; v.gh = gh;
    return v;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic drive(input vec_t v);
    bus.core_req = v.cr; bus.core_we = v.cw; bus.core_addr = v.ca; bus.core_wdata = v.cd;
    bus.host_req = v.hr; bus.host_we = v.hw; bus.host_lock = v.hl;
    bus.host_addr = v.ha; bus.host_wdata = v.hd;
  endtask
  task automatic step(input vec_t v);
    logic e_we;
    logic [7:0] e_addr, e_wd;
    drive(v);
    #3;
    chk("core_gnt", 32'(bus.core_gnt), 32'(v.gc));
    chk("host_gnt", 32'(bus.host_gnt), 32'(v.gh));
    e_we = v.gc ? v.cw : v.gh & v.hw;
    e_addr = v.gc ? v.ca : v.gh ? v.ha : last_addr;
    e_wd = v.gc ? v.cd : v.gh ? v.hd : last_wd;
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd));
    if (v.gc && !v.cw) qc.push_back(shadow[v.ca]);
    if (v.gh && !v.hw) qh.push_back(shadow[v.ha]);
    if (e_we) shadow[e_addr] = e_wd;
    if (v.gc || v.gh) begin last_addr = e_addr; last_wd = e_wd; end
    if (v.cr && v.hr && conf != 15) conf++;
    @(posedge Clk); #1;
    chk("core_rvalid", 32'(bus.core_rvalid), 32'(qc.size() != 0));
    if (qc.size() != 0) chk("core_rdata", 32'(bus.core_rdata), 32'(qc.pop_front()));
    chk("host_rvalid", 32'(bus.host_rvalid), 32'(qh.size() != 0));
    if (qh.size() != 0) chk("host_rdata", 32'(bus.host_rdata), 32'(qh.pop_front()));
    chk("conflict_ct", 32'(bus.conflict_ct), 32'(conf));
  endtask
  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    Reset = 1'b1;
    #1;
    chk("rst_core_rvalid", 32'(bus.core_rvalid), 0);
    chk("rst_host_rvalid", 32'(bus.host_rvalid), 0);
    chk("rst_core_rdata", 32'(bus.core_rdata), 0);
    chk("rst_host_rdata", 32'(bus.host_rdata), 0);
    chk("rst_conflict_ct", 32'(bus.conflict_ct), 0);
    @(posedge Clk); #1;
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_core_rvalid_edge", 32'(bus.core_rvalid), 0);
    chk("rst_conflict_edge", 32'(bus.conflict_ct), 0);
    Reset = 1'b0;
    qc.delete(); qh.delete();
    conf = 0; last_addr = '0; last_wd = '0;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    tbl.push_back(mk(1, 0, 8'h10, 0, 1, 0, 0, 8'h11, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h10, 0, 1, 0, 0, 8'h11, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h10, 0, 1, 0, 0, 8'h11, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h10, 0, 1, 0, 0, 8'h11, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 8'h10, 8'hA5, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h10, 0, 0, 1));
    tbl.push_back(mk(1, 1, 8'h30, 8'h33, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h10, 8'h77, 1, 1, 0, 8'h10, 8'h5A, 0, 1));
    tbl.push_back(mk(1, 0, 8'h10, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h44, 8'h66, 0, 1, 0, 8'h55, 8'h99, 0, 0));
    tbl.push_back(mk(1, 0, 8'h30, 0, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h30, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h10, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h11, 0, 0, 1));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    do_reset();
    foreach (tbl[i]) step(tbl[i]);
    step(mk(1, 0, 8'h30, 0, 0, 0, 0, 0, 0, 1, 0));
    // Host wins once by round-robin, then 16 locked grants before the forced core slot
    for (int i = 0; i < 20; i++)
      step(mk(1, 0, 8'h30, 0, 1, 0, 1, 8'h10, 0, i == 17, i != 17));
    step(mk(1, 0, 8'h10, 0, 1, 0, 0, 8'h30, 0, 1, 0));
    drive(mk(1, 0, 8'h30, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    chk("midreset_core_gnt", 32'(bus.core_gnt), 1);
    do_reset();
    for (int i = 0; i < 20; i++)
      step(mk(1, 0, 8'h10, 0, 1, 0, 0, 8'h30, 0, i % 2 == 0, i % 2 == 1));
    chk("conflict_saturated", 32'(bus.conflict_ct), 15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
